// File: rtl/uart_rx_word.sv
// Purpose: 8N1 UART receiver (8E1 with UART_RX_PARITY_EN) that packs four bytes MSB-first into a 32-bit word.
// Latency: data_valid pulses one cycle after the stop-bit sample of the fourth byte; the word is held until the next one.
// Backpressure: none, the serial line cannot be stalled; partial words are dropped after TIMEOUT_BITS idle bit periods.
module uart_rx_word #(
    parameter int CLK_FREQ     = 100000000,
    parameter int BAUD         = 115200,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic        frame_err,
    output logic        parity_err,
    output logic        busy
);

    localparam int BIT_CYC  = CLK_FREQ / BAUD;
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int TO_CYC   = TIMEOUT_BITS * BIT_CYC;
    localparam int CW       = $clog2(BIT_CYC + 1);
    localparam int TW       = $clog2(TO_CYC + 1);

    localparam logic [CW-1:0] BIT_M1  = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF_CYC - 1);
    localparam logic [TW-1:0] TO_M1   = TW'(TO_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [1:0]    byte_cnt;
    logic [23:0]   word_acc;
    logic [TW-1:0] idle_cnt;
    logic          fall;
`ifdef UART_RX_PARITY_EN
    logic          par_bad;
`else
    assign parity_err = 1'b0;
`endif

    assign fall = rx_prev & ~rx_sync;
    assign busy = (state != IDLE) || (byte_cnt != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_cnt   <= '0;
            word_acc   <= '0;
            idle_cnt   <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
            par_bad    <= 1'b0;
`endif
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            idle_cnt   <= '0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (fall) begin
                        state   <= START;
                        cnt     <= '0;
                        bit_idx <= '0;
                    end else if (byte_cnt != 2'd0) begin
                        // Partial word left hanging too long: drop it without a pulse.
                        if (idle_cnt == TO_M1) begin
                            byte_cnt <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt   <= '0;
                        state <= rx_sync ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_M1) begin
                        cnt     <= '0;
                        shift   <= {rx_sync, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == BIT_M1) begin
                        cnt     <= '0;
                        par_bad <= rx_sync != (^shift);
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cnt == BIT_M1) begin
                        cnt <= '0;
                        if (!rx_sync) begin
                            frame_err <= 1'b1;
                            byte_cnt  <= '0;
                            state     <= WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
                        end else if (par_bad) begin
                            parity_err <= 1'b1;
                            byte_cnt   <= '0;
                            state      <= IDLE;
`endif
                        end else begin
                            state <= IDLE;
                            if (byte_cnt == 2'd3) begin
                                data_out   <= {word_acc, shift};
                                data_valid <= 1'b1;
                                byte_cnt   <= '0;
                            end else begin
                                word_acc <= {word_acc[15:0], shift};
                                byte_cnt <= byte_cnt + 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    // A line held low after a framing error must not look like a new start bit.
                    if (rx_sync) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_word.sv
// Directed bench for uart_rx_word: table of word/byte frames plus hand sequences for
// framing errors, held-low line, glitch rejection, mid-frame reset and (optionally) parity.
module tb_uart_rx_word;

    localparam int CLK_FREQ = 3200000;
    localparam int BAUD     = 100000;
    localparam int BITC     = CLK_FREQ / BAUD;
    localparam int HALF     = BITC / 2;
    localparam int TO_BITS  = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic [31:0] data_out;
    logic        data_valid;
    logic        frame_err;
    logic        parity_err;
    logic        busy;

    uart_rx_word #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD(BAUD),
        .TIMEOUT_BITS(TO_BITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .data_out(data_out),
        .data_valid(data_valid),
        .frame_err(frame_err),
        .parity_err(parity_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int vld_cnt = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    int ovl_cnt = 0;

    always @(negedge clk) begin
        if (data_valid === 1'b1) vld_cnt++;
        if (frame_err === 1'b1) ferr_cnt++;
        if (parity_err === 1'b1) perr_cnt++;
        if ($countones({data_valid === 1'b1, frame_err === 1'b1, parity_err === 1'b1}) > 1) ovl_cnt++;
    end

    typedef struct {
        int          nbytes;
        logic [31:0] bytes;
        int          bad_last;
        int          gap_bits;
        logic [31:0] exp_dout;
        int          exp_vld;
        int          exp_ferr;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[10];

`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (BITC) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^b) ^ par_flip);
`endif
        send_bit(!bad_stop);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], 1'b0);
    endtask

    initial begin
        int v0, f0, p0;
        vecs[0] = '{4, 32'h12345678, 0, 2,  32'h12345678, 1, 0, 1'b0};
        vecs[1] = '{4, 32'h00FF00FF, 0, 2,  32'h00FF00FF, 1, 0, 1'b0};
        vecs[2] = '{1, 32'hA5000000, 1, 2,  32'h00FF00FF, 0, 1, 1'b0};
        vecs[3] = '{2, 32'h99880000, 1, 2,  32'h00FF00FF, 0, 1, 1'b0};
        vecs[4] = '{4, 32'hCAFEF00D, 0, 2,  32'hCAFEF00D, 1, 0, 1'b0};
        vecs[5] = '{2, 32'h11220000, 0, 25, 32'hCAFEF00D, 0, 0, 1'b1};
        vecs[6] = '{4, 32'hAABBCCDD, 0, 2,  32'hAABBCCDD, 1, 0, 1'b0};
        vecs[7] = '{1, 32'h55000000, 0, 5,  32'hAABBCCDD, 0, 0, 1'b1};
        vecs[8] = '{3, 32'h66778800, 0, 2,  32'h55667788, 1, 0, 1'b0};
        vecs[9] = '{4, 32'h80000001, 0, 2,  32'h80000001, 1, 0, 1'b0};

        rx  = 1'b1;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_data_valid", {31'b0, data_valid}, 32'h0);
        chk("rst_frame_err", {31'b0, frame_err}, 32'h0);
        chk("rst_parity_err", {31'b0, parity_err}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        for (int n = 0; n < 10; n++) begin
            v0 = vld_cnt;
            f0 = ferr_cnt;
            for (int i = 0; i < vecs[n].nbytes; i++)
                send_byte(vecs[n].bytes[31-8*i -: 8],
                          (vecs[n].bad_last != 0) && (i == vecs[n].nbytes - 1));
            send_bit(1'b1);
            chk($sformatf("vec%0d_busy", n), {31'b0, busy}, {31'b0, vecs[n].exp_busy});
            repeat (vecs[n].gap_bits) send_bit(1'b1);
            chk($sformatf("vec%0d_busy_after_gap", n), {31'b0, busy},
                {31'b0, vecs[n].exp_busy && (vecs[n].gap_bits + 1 < TO_BITS)});
            chk($sformatf("vec%0d_data_out", n), data_out, vecs[n].exp_dout);
            chk($sformatf("vec%0d_valid_pulses", n), vld_cnt - v0, vecs[n].exp_vld);
            chk($sformatf("vec%0d_frame_err_pulses", n), ferr_cnt - f0, vecs[n].exp_ferr);
        end

        // Bad stop bit, then the line is held low for three more bit periods.
        v0 = vld_cnt;
        f0 = ferr_cnt;
        send_byte(8'hA5, 1'b1);
        repeat (3) send_bit(1'b0);
        send_bit(1'b1);
        chk("held_low_frame_err", ferr_cnt - f0, 1);
        chk("held_low_busy", {31'b0, busy}, 32'h0);
        send_word(32'hDEADBEEF);
        send_bit(1'b1);
        chk("held_low_data_out", data_out, 32'hDEADBEEF);
        chk("held_low_valid", vld_cnt - v0, 1);

        // Short low glitch: start detected, rejected at the half-bit check.
        v0 = vld_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        repeat (10) @(negedge clk);
        rx = 1'b1;
        chk("glitch_busy_seen", {31'b0, busy}, 32'h1);
        repeat (HALF + 10) @(negedge clk);
        chk("glitch_busy_cleared", {31'b0, busy}, 32'h0);
        repeat (2 * BITC) @(negedge clk);
        chk("glitch_busy_stays_low", {31'b0, busy}, 32'h0);
        chk("glitch_valid", vld_cnt - v0, 0);
        chk("glitch_frame_err", ferr_cnt - f0, 0);

        // Reset during data bit 4 (a 1) of the third byte.
        f0 = ferr_cnt;
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        rx = 1'b1;
        repeat (HALF) @(negedge clk);
        chk("midframe_busy", {31'b0, busy}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("midframe_rst_data_out", data_out, 32'h0);
        chk("midframe_rst_busy", {31'b0, busy}, 32'h0);
        chk("midframe_rst_valid", {31'b0, data_valid}, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) send_bit(1'b1);
        chk("midframe_no_pulse", ferr_cnt - f0, 0);
        chk("midframe_idle_busy", {31'b0, busy}, 32'h0);
        v0 = vld_cnt;
        send_word(32'h01020304);
        send_bit(1'b1);
        chk("after_rst_data_out", data_out, 32'h01020304);
        chk("after_rst_valid", vld_cnt - v0, 1);

`ifdef UART_RX_PARITY_EN
        v0 = vld_cnt;
        p0 = perr_cnt;
        par_flip = 1'b1;
        send_byte(8'h03, 1'b0);
        par_flip = 1'b0;
        send_bit(1'b1);
        chk("parity_err_pulse", perr_cnt - p0, 1);
        chk("parity_busy", {31'b0, busy}, 32'h0);
        send_word(32'h0A0B0C0D);
        send_bit(1'b1);
        chk("parity_data_out", data_out, 32'h0A0B0C0D);
        chk("parity_valid", vld_cnt - v0, 1);
`else
        p0 = 0;
        chk("parity_err_never", perr_cnt - p0, 0);
`endif
        chk("pulse_overlap", ovl_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
